vga_sync_receiver: RTL and testbench
====================================

# vga_sync_receiver

Sink-side VGA timing recovery for pixel-clock-domain video streams (hsync/vsync/DE, sync active-low). Rebuilds active-pixel x/y coordinates from incoming sync and DE, measures horizontal and vertical timing, and declares lock once consecutive frames match. Sits at the input of capture/overlay pipelines that receive video from a 640x480@60 timing generator or an external source clocked at the same pixel rate.

## Interface
- LOCK_FRAMES, 2: number of consecutive consistent complete frames required before `locked` asserts (1..15).
- clk  in  1  pixel clock (25 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- de_in  in  1  data enable, high during visible pixels
- x  out  10  active column index of the current pixel
- y  out  10  active line index of the current pixel
- pixel_valid  out  1  `x`/`y` describe a visible pixel
- line_start  out  1  one-cycle pulse with the first pixel of each active line
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- locked  out  1  timing stable and matching reference
- h_total, h_active, v_total, v_active  out  10 each  locked reference timing (clocks/line, pixels/line, lines/frame, active lines/frame)
- timing_err  out  1  one-cycle pulse on loss of lock
- err_count  out  8  lock-loss counter (see Configuration)

## Operation
- Input stage: `hsync_in`, `vsync_in`, `de_in` registered once (`_q`), then again (`_d`) for edge detection. HS edge = hs_q=0 & hs_d=1; VS edge = vs falling likewise; DE rise/fall from de_q/de_d.
- h_cnt: cleared on HS edge, else +1, saturating at 1023. Line period on HS edge = h_cnt+1.
- de_run: set to 1 on DE rise, +1 while de_q=1; DE width = de_run at DE fall.
- v_cnt: +1 on each HS edge, cleared on VS edge; frame lines = v_cnt at VS edge (v_cnt+1 if HS and VS edges coincide). act_lines: +1 on DE rise, captured and cleared on VS edge.
- Coordinates: x = de_run-1 of current pixel; y = count of DE falls since last VS edge. pixel_valid = de_q delayed one register.
- FSM states SEARCH, VERIFY, LOCKED; `frame_bad` sticky flag cleared on each VS edge.
- SEARCH: every HS edge stores period into ref_h_total, setting frame_bad if it differs from previous value; every DE fall likewise for ref_h_active. First VS edge after entry only sets seen_vs. Later VS edge with frame_bad=0: store ref_v_total/ref_v_active, match_cnt=1, -> VERIFY (-> LOCKED directly if LOCK_FRAMES=1).
- VERIFY/LOCKED: every HS period, DE width compared to refs; at VS edge, frame lines/act_lines compared. Any mismatch or h_cnt reaching 1023 = fault.
- VERIFY: fault -> SEARCH (seen_vs=1 if fault on VS edge, else 0). Clean VS edge: match_cnt+1; reaching LOCK_FRAMES -> LOCKED.
- LOCKED: fault -> timing_err pulse, err_count+1, -> SEARCH with seen_vs=0.
- h_total..v_active outputs show refs only while locked, else 0.

## Timing
- All outputs registered; reset value 0 for every output, counter, ref and state=SEARCH.
- x, y, pixel_valid, line_start, frame_start lag `de_in` by 2 clk; downstream delays pixel data by 2.
- line_start = pixel_valid & x=0; frame_start = pixel_valid & x=0 & y=0; both only while locked.
- locked rises/falls 2 clk after the `vsync_in`/`hsync_in`/`de_in` sample causing the transition; timing_err coincides with locked falling.
- Coincident HS and VS edges: HS counted into the closing frame before VS comparison.
- rst_n assert mid-frame: immediate return to reset values; relock requires full SEARCH sequence.

## Configuration
- VGA_RX_ERR_CNT_EN defined: err_count increments on every lock loss, saturates at 255, cleared only by reset.
- Undefined: counter logic absent, err_count tied to 0; all other behaviour identical.

## Test plan
- Reset held, random sync toggling -> all outputs 0, locked=0.
- Standard 640x480 stream (800 clk/line, 525 lines, hsync low 96, vsync low 2 lines), LOCK_FRAMES=2 -> locked 2 clk after 3rd vsync fall; h_total=800, h_active=640, v_total=525, v_active=480.
- Locked stream -> frame_start 2 clk after first DE of line 0; last pixel x=639, y=479; 480 line_start pulses per frame.
- One 801-clk line injected while locked -> single timing_err pulse, locked=0, err_count=1 (0 without VGA_RX_ERR_CNT_EN); relock after 3 clean vsync falls.
- hsync held high while locked -> fault when h_cnt hits 1023; timing_err, locked=0.
- rst_n pulsed mid-frame while locked -> outputs 0 asynchronously; relock after 3rd vsync fall post-release.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//
// Sink-side VGA timing recovery in the pixel-clock domain. Rebuilds active-pixel
// coordinates from hsync/vsync/DE (syncs active-low), measures line and frame
// timing, and declares lock after LOCK_FRAMES consecutive consistent frames.
//
// Optional feature: define VGA_RX_ERR_CNT_EN to build the saturating lock-loss
// counter behind err_count; when undefined err_count is tied to 0.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   hsync_in     horizontal sync, active-low
//   vsync_in     vertical sync, active-low
//   de_in        data enable, high during visible pixels
//   x, y         active column / line of the current pixel
//   pixel_valid  x/y describe a visible pixel (2 clk behind de_in)
//   line_start   pulse with the first pixel of each line (locked only)
//   frame_start  pulse with pixel (0,0) (locked only)
//   locked       timing stable and matching the stored reference
//   h_total, h_active, v_total, v_active  reference timing while locked, else 0
//   timing_err   one-cycle pulse when lock is lost
//   err_count    lock-loss count (saturating, only with VGA_RX_ERR_CNT_EN)

module vga_sync_receiver #(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       de_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pixel_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic [9:0] h_total,
  output logic [9:0] h_active,
  output logic [9:0] v_total,
  output logic [9:0] v_active,
  output logic       timing_err,
  output logic [7:0] err_count
);

  localparam logic [9:0] CntMax     = 10'h3ff;
  localparam logic [3:0] LockTarget = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  // Input stage: *_q is the first register, *_d the second (used for edges).
  logic hs_q, hs_d, vs_q, vs_d, de_q, de_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b0;
      hs_d <= 1'b0;
      vs_q <= 1'b0;
      vs_d <= 1'b0;
      de_q <= 1'b0;
      de_d <= 1'b0;
    end else begin
      hs_q <= hsync_in;
      hs_d <= hs_q;
      vs_q <= vsync_in;
      vs_d <= vs_q;
      de_q <= de_in;
      de_d <= de_q;
    end
  end

  logic hs_edge, vs_edge, de_rise, de_fall;

  assign hs_edge = ~hs_q & hs_d;
  assign vs_edge = ~vs_q & vs_d;
  assign de_rise = de_q & ~de_d;
  assign de_fall = ~de_q & de_d;

  // Measurement counters
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] de_run_q, de_run_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [9:0] act_lines_q, act_lines_d;
  logic [9:0] line_cnt_q, line_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    if (hs_edge) begin
      h_cnt_d = '0;
    end else if (h_cnt_q != CntMax) begin
      h_cnt_d = h_cnt_q + 10'd1;
    end

    de_run_d = de_run_q;
    if (de_rise) begin
      de_run_d = 10'd1;
    end else if (de_q && (de_run_q != CntMax)) begin
      de_run_d = de_run_q + 10'd1;
    end

    v_cnt_d = v_cnt_q;
    if (vs_edge) begin
      v_cnt_d = '0;
    end else if (hs_edge && (v_cnt_q != CntMax)) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end

    act_lines_d = act_lines_q;
    if (vs_edge) begin
      act_lines_d = '0;
    end else if (de_rise && (act_lines_q != CntMax)) begin
      act_lines_d = act_lines_q + 10'd1;
    end

    // Active line index: DE falls since the last vsync edge
    line_cnt_d = line_cnt_q;
    if (vs_edge) begin
      line_cnt_d = '0;
    end else if (de_fall && (line_cnt_q != CntMax)) begin
      line_cnt_d = line_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q     <= '0;
      de_run_q    <= '0;
      v_cnt_q     <= '0;
      act_lines_q <= '0;
      line_cnt_q  <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      de_run_q    <= de_run_d;
      v_cnt_q     <= v_cnt_d;
      act_lines_q <= act_lines_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  // Line period and frame line count; an HS edge coincident with the VS edge
  // belongs to the frame being closed.
  logic [10:0] h_period, frame_lines;

  assign h_period    = {1'b0, h_cnt_q} + 11'd1;
  assign frame_lines = {1'b0, v_cnt_q} + {10'd0, hs_edge};

  // Lock FSM and reference registers
  state_e     state_q, state_d;
  logic       seen_vs_q, seen_vs_d;
  logic       frame_bad_q, frame_bad_d;
  logic [3:0] match_cnt_q, match_cnt_d;
  logic [3:0] match_nxt;
  logic [9:0] ref_h_total_q, ref_h_total_d;
  logic [9:0] ref_h_active_q, ref_h_active_d;
  logic [9:0] ref_v_total_q, ref_v_total_d;
  logic [9:0] ref_v_active_q, ref_v_active_d;
  logic       h_mis, a_mis, v_mis, h_stall, fault, err_pulse;

  assign h_mis   = hs_edge && (h_period != {1'b0, ref_h_total_q});
  assign a_mis   = de_fall && (de_run_q != ref_h_active_q);
  assign v_mis   = vs_edge && ((frame_lines != {1'b0, ref_v_total_q}) ||
                               (act_lines_q != ref_v_active_q));
  assign h_stall = (h_cnt_q == CntMax);
  assign fault   = h_mis | a_mis | v_mis | h_stall;
  assign match_nxt = match_cnt_q + 4'd1;

  always_comb begin
    state_d        = state_q;
    seen_vs_d      = seen_vs_q;
    frame_bad_d    = frame_bad_q;
    match_cnt_d    = match_cnt_q;
    ref_h_total_d  = ref_h_total_q;
    ref_h_active_d = ref_h_active_q;
    ref_v_total_d  = ref_v_total_q;
    ref_v_active_d = ref_v_active_q;
    err_pulse      = 1'b0;

    unique case (state_q)
      StSearch: begin
        // Track the latest horizontal timing; any change spoils this frame.
        if (hs_edge) ref_h_total_d = h_period[9:0];
        if (de_fall) ref_h_active_d = de_run_q;
        if (h_mis || a_mis) frame_bad_d = 1'b1;
        if (vs_edge) begin
          frame_bad_d = 1'b0;
          if (!seen_vs_q) begin
            seen_vs_d = 1'b1;
          end else if (!frame_bad_q && !h_mis && !a_mis) begin
            ref_v_total_d  = frame_lines[9:0];
            ref_v_active_d = act_lines_q;
            match_cnt_d    = 4'd1;
            state_d        = (LOCK_FRAMES <= 1) ? StLocked : StVerify;
          end
        end
      end
      StVerify: begin
        if (fault) begin
          state_d     = StSearch;
          seen_vs_d   = vs_edge;
          frame_bad_d = 1'b0;
          match_cnt_d = '0;
        end else if (vs_edge) begin
          match_cnt_d = match_nxt;
          if (match_nxt >= LockTarget) state_d = StLocked;
        end
      end
      StLocked: begin
        if (fault) begin
          state_d     = StSearch;
          seen_vs_d   = 1'b0;
          frame_bad_d = 1'b0;
          match_cnt_d = '0;
          err_pulse   = 1'b1;
        end
      end
      default: begin
        state_d = StSearch;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StSearch;
      seen_vs_q      <= 1'b0;
      frame_bad_q    <= 1'b0;
      match_cnt_q    <= '0;
      ref_h_total_q  <= '0;
      ref_h_active_q <= '0;
      ref_v_total_q  <= '0;
      ref_v_active_q <= '0;
    end else begin
      state_q        <= state_d;
      seen_vs_q      <= seen_vs_d;
      frame_bad_q    <= frame_bad_d;
      match_cnt_q    <= match_cnt_d;
      ref_h_total_q  <= ref_h_total_d;
      ref_h_active_q <= ref_h_active_d;
      ref_v_total_q  <= ref_v_total_d;
      ref_v_active_q <= ref_v_active_d;
    end
  end

  // Output registers
  logic       lock_nxt, first_px;
  logic [9:0] x_q, y_q, h_total_q, h_active_q, v_total_q, v_active_q;
  logic       pixel_valid_q, line_start_q, frame_start_q, locked_q, timing_err_q;

  assign lock_nxt = (state_d == StLocked);
  assign first_px = de_q && (de_run_d == 10'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= '0;
      y_q           <= '0;
      pixel_valid_q <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
      h_total_q     <= '0;
      h_active_q    <= '0;
      v_total_q     <= '0;
      v_active_q    <= '0;
    end else begin
      x_q           <= de_q ? (de_run_d - 10'd1) : '0;
      y_q           <= de_q ? line_cnt_q : '0;
      pixel_valid_q <= de_q;
      line_start_q  <= first_px & lock_nxt;
      frame_start_q <= first_px & lock_nxt & (line_cnt_q == '0);
      locked_q      <= lock_nxt;
      timing_err_q  <= err_pulse;
      h_total_q     <= lock_nxt ? ref_h_total_d : '0;
      h_active_q    <= lock_nxt ? ref_h_active_d : '0;
      v_total_q     <= lock_nxt ? ref_v_total_d : '0;
      v_active_q    <= lock_nxt ? ref_v_active_d : '0;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pixel_valid = pixel_valid_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign timing_err  = timing_err_q;
  assign h_total     = h_total_q;
  assign h_active    = h_active_q;
  assign v_total     = v_total_q;
  assign v_active    = v_active_q;

`ifdef VGA_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_pulse && (err_cnt_q != 8'hff)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
`timescale 1ns / 1ps

// Directed bench for vga_sync_receiver using a reduced raster so each frame is
// short: 100 clk/line (64 active, hsync low 80..89), 30 lines/frame (24 active,
// vsync low on lines 26..27).
module tb_vga_sync_receiver;

  localparam int H_TOT    = 100;
  localparam int H_ACT    = 64;
  localparam int HS_START = 80;
  localparam int HS_LEN   = 10;
  localparam int V_TOT    = 30;
  localparam int V_ACT    = 24;
  localparam int VS_START = 26;
  localparam int VS_LEN   = 2;
  localparam int FRAME    = H_TOT * V_TOT;
`ifdef VGA_RX_ERR_CNT_EN
  localparam int ERR_INC = 1;
`else
  localparam int ERR_INC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       de_in = 1'b0;
  logic [9:0] x, y, h_total, h_active, v_total, v_active;
  logic       pixel_valid, line_start, frame_start, locked, timing_err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int pos_l = 0;
  int pos_p = 0;
  int line_len = H_TOT;
  int ls_cnt = 0;
  int fs_cnt = 0;

  vga_sync_receiver #(.LOCK_FRAMES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .de_in      (de_in),
    .x          (x),
    .y          (y),
    .pixel_valid(pixel_valid),
    .line_start (line_start),
    .frame_start(frame_start),
    .locked     (locked),
    .h_total    (h_total),
    .h_active   (h_active),
    .v_total    (v_total),
    .v_active   (v_active),
    .timing_err (timing_err),
    .err_count  (err_count)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive n raster positions, one per clock; outputs are sampled 1 ns after the edge.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      hsync_in = !(pos_p >= HS_START && pos_p < HS_START + HS_LEN);
      vsync_in = !(pos_l >= VS_START && pos_l < VS_START + VS_LEN);
      de_in    = (pos_l < V_ACT) && (pos_p < H_ACT);
      @(posedge clk);
      #1;
      if (line_start) ls_cnt++;
      if (frame_start) fs_cnt++;
      pos_p++;
      if (pos_p >= line_len) begin
        pos_p    = 0;
        line_len = H_TOT;
        pos_l    = (pos_l + 1 == V_TOT) ? 0 : pos_l + 1;
      end
    end
  endtask

  // Advance until (l,p) is the next position to be driven.
  task automatic adv_to(input int l, input int p);
    int guard;
    guard = 0;
    while (!(pos_l == l && pos_p == p) && guard < 2 * FRAME + 10) begin
      adv(1);
      guard++;
    end
    if (guard >= 2 * FRAME + 10) begin
      errors++;
      $error("FAIL adv_to: position %0d,%0d not reached", l, p);
    end
  endtask

  initial begin
    int first_s;
    int pulses;

    // Reset held with random sync activity
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      hsync_in = 1'($urandom());
      vsync_in = 1'($urandom());
      de_in    = 1'($urandom());
      @(posedge clk);
      #1;
    end
    chk("rst_locked", locked, 0);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_line_start", line_start, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_h_total", h_total, 0);
    chk("rst_h_active", h_active, 0);
    chk("rst_v_total", v_total, 0);
    chk("rst_v_active", v_active, 0);
    chk("rst_timing_err", timing_err, 0);
    chk("rst_err_count", err_count, 0);

    hsync_in = 1'b1;
    vsync_in = 1'b1;
    de_in    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Lock: 3rd vsync fall is frame 2 line 26
    adv(2 * FRAME);
    adv_to(VS_START, 0);
    chk("prelock_h_total", h_total, 0);
    adv(1);
    chk("lock_not_yet", locked, 0);
    adv(1);
    chk("lock_rise", locked, 1);
    chk("lock_h_total", h_total, H_TOT);
    chk("lock_h_active", h_active, H_ACT);
    chk("lock_v_total", v_total, V_TOT);
    chk("lock_v_active", v_active, V_ACT);

    // Frame 3: coordinates and start pulses
    adv_to(0, 0);
    ls_cnt = 0;
    fs_cnt = 0;
    adv(1);
    chk("fs_not_early", frame_start, 0);
    adv(1);
    chk("fs_pulse", frame_start, 1);
    chk("fs_line_start", line_start, 1);
    chk("fs_valid", pixel_valid, 1);
    chk("fs_x0", x, 0);
    chk("fs_y0", y, 0);
    adv(1);
    chk("fs_single", frame_start, 0);
    chk("px1_x", x, 1);
    adv_to(V_ACT - 1, H_ACT - 1);
    adv(2);
    chk("last_x", x, H_ACT - 1);
    chk("last_y", y, V_ACT - 1);
    chk("last_valid", pixel_valid, 1);
    adv(1);
    chk("after_last_valid", pixel_valid, 0);
    adv_to(VS_START, 0);
    chk("line_start_count", ls_cnt, V_ACT);
    chk("frame_start_count", fs_cnt, 1);

    // Frame 4: line 5 stretched by one clock
    adv_to(5, 0);
    line_len = H_TOT + 1;
    adv_to(6, HS_START);
    adv(1);
    chk("inj_still_locked", locked, 1);
    chk("inj_no_err_yet", timing_err, 0);
    adv(1);
    chk("inj_err_pulse", timing_err, 1);
    chk("inj_unlocked", locked, 0);
    chk("inj_h_total_zero", h_total, 0);
    chk("inj_err_count", err_count, ERR_INC);
    adv(1);
    chk("inj_err_single", timing_err, 0);

    // Relock on the 3rd vsync fall after the fault
    adv_to(VS_START, 0);
    adv(2 * FRAME);
    adv(1);
    chk("relock_not_yet", locked, 0);
    adv(1);
    chk("relock_rise", locked, 1);
    chk("relock_h_total", h_total, H_TOT);

    // Asynchronous reset mid-frame while locked
    adv_to(10, 30);
    chk("mid_x", x, 28);
    chk("mid_y", y, 10);
    chk("mid_locked", locked, 1);
    #5 rst_n = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_valid", pixel_valid, 0);
    chk("arst_x", x, 0);
    chk("arst_v_total", v_total, 0);
    chk("arst_err_count", err_count, 0);
    adv(5);
    rst_n = 1'b1;
    adv_to(VS_START, 0);
    adv(2 * FRAME);
    adv(1);
    chk("rst_relock_not_yet", locked, 0);
    adv(1);
    chk("rst_relock_rise", locked, 1);

    // hsync stuck high: last HS edge is line 29 pixel 80; h_cnt hits 1023
    // after the 19 remaining line clocks plus 1005 idle clocks.
    adv_to(0, 0);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    de_in    = 1'b0;
    first_s  = 0;
    pulses   = 0;
    for (int s = 1; s <= 1100; s++) begin
      @(posedge clk);
      #1;
      if (timing_err) begin
        pulses++;
        if (first_s == 0) first_s = s;
      end
    end
    chk("stall_err_time", first_s, 1006);
    chk("stall_err_pulses", pulses, 1);
    chk("stall_unlocked", locked, 0);
    chk("stall_err_count", err_count, ERR_INC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
